nibble_serial_adder_ctrl: RTL and testbench
===========================================

# nibble_serial_adder_ctrl

Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one 4-bit carry-lookahead slice, one nibble per clock, LSB nibble first. A registered carry links consecutive nibbles. Operands enter through a valid/ready handshake and results leave through one. It sits between an operand source (register file / ALU front end) and a result consumer, and trades latency for area against a full-width CLA.

## Interface
Parameters:
- WIDTH, 16, operand width; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived; not overridden.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand request
- in_ready  out  1  block can accept; high only in IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  1 = A − B, 0 = A + B + cin
- cin  in  1  carry-in; ignored when sub=1
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB; when sub=1, 1 = no borrow (A ≥ B unsigned)
- ovf  out  1  two's-complement overflow

## Operation
- Slice, per bit i: p = a^b, g = a&b; c(i+1) = g | (p & c(i)), with all four carries in lookahead form; sum(i) = p ^ c(i).
- State machine: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid & in_ready:
  - latch a into op_a and (sub ? ~b : b) into op_b;
  - set carry reg = sub ? 1 : cin; set nibble index = 0;
  - clear sum, cout, ovf; go to RUN.
- RUN: each cycle, apply nibble[index] of op_a/op_b plus carry reg to the slice.
  - Write the slice sum into sum[4*index+3 : 4*index].
  - Carry reg <= slice cout; index++.
  - At index == NIBBLES−1: cout <= slice cout; ovf <= slice c3 ^ slice cout, where c3 is the carry into the MSB; go to DONE.
- DONE: out_valid=1. sum, cout and ovf are held stable until out_ready=1; then go to IDLE.
- Operand inputs are sampled only on the accept edge. Later changes to a, b, sub or cin have no effect.
- in_valid in RUN or DONE is ignored (in_ready=0). No request is queued.
- WIDTH=4 (NIBBLES=1): RUN lasts one cycle.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, index=0, carry=0;
  - out_valid=0, sum=0, cout=0, ovf=0; in_ready=1 on the following cycle.
  - Reset mid-RUN or mid-DONE aborts the operation. No result is presented.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from inputs to outputs.
- Accept at edge T → RUN during cycles T..T+NIBBLES−1 → out_valid high from edge T+NIBBLES. Latency is NIBBLES cycles.
- Result handshake completes at the first edge with out_valid & out_ready. out_valid drops and in_ready rises on that same edge.
- The earliest next accept is one cycle after the result handshake. Minimum issue interval is NIBBLES+2 cycles with out_ready held high.
- Partial nibbles of sum may be visible during RUN. They are valid only while out_valid=1.

## Test plan (WIDTH=16)
- Add 0x1234 + 0x0FFF, cin=0 → sum=0x2233, cout=0, ovf=0. out_valid rises exactly 4 cycles after the accept edge.
- Add 0xFFFF + 0x0001 → sum=0x0000, cout=1, ovf=0; the carry propagates through all 4 nibbles. Add 0x7FFF + 0x0001 → sum=0x8000, cout=0, ovf=1.
- Sub 0x0005 − 0x0007 → sum=0xFFFE, cout=0, ovf=0. Sub 0x8000 − 0x0001 → sum=0x7FFF, cout=1, ovf=1. Sub with cin=1 gives the same results (cin ignored).
- Backpressure:
  - hold out_ready=0 for 5 cycles in DONE → sum/cout/ovf stable, in_ready=0;
  - new in_valid with different operands is ignored;
  - out_ready=1 → IDLE next cycle, and the following op is correct.
- Operand stability: change a/b every cycle during RUN → result reflects only the values latched at accept.
- Reset: assert rst_n=0 for 1 cycle while index=2 in RUN → next cycle IDLE, outputs 0, out_valid never asserted for the aborted op. A fresh 0x0001 + 0x0001 → 0x0002.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand and result handshake bundle for the nibble-serial adder.
// master = operand source / result consumer, slave = the adder.
interface nibble_serial_adder_ctrl_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/subtract built from one 4-bit carry-lookahead slice reused once per nibble,
// LSB nibble first, with a registered carry chaining the nibbles.
module nibble_serial_adder_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input logic                        clk,
  input logic                        rst_n,
  nibble_serial_adder_ctrl_if.slave  bus
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q;
  logic [WIDTH-1:0]  op_a_q;
  logic [WIDTH-1:0]  op_b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;
  logic [3:0] slice_sum;

  // Lookahead slice: all carries expressed directly from p, g and the carry-in.
  always_comb begin
    nib_a = op_a_q[{idx_q, 2'b00} +: 4];
    nib_b = op_b_q[{idx_q, 2'b00} +: 4];
    p     = nib_a ^ nib_b;
    g     = nib_a & nib_b;
    c[0]  = carry_q;
    c[1]  = g[0] | (p[0] & carry_q);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & carry_q);
    slice_sum = p ^ c[3:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            // Subtraction is A + ~B + 1, so cin is replaced by the forced carry.
            op_a_q  <= bus.a;
            op_b_q  <= bus.sub ? ~bus.b : bus.b;
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= StRun;
          end
        end
        StRun: begin
          sum_q[{idx_q, 2'b00} +: 4] <= slice_sum;
          carry_q                    <= c[4];
          if (idx_q == LastIdx) begin
            cout_q  <= c[4];
            ovf_q   <= c[3] ^ c[4];
            state_q <= StDone;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl at WIDTH=16: expected results are queued
// at the accept edge and compared when the result handshake happens.
module tb_nibble_serial_adder_ctrl;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned Bound = 50;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  // {cout, ovf, sum}
  logic [WIDTH+1:0] exp_q[$];

  nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent full-width reference model.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic sub, input logic cin);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    logic             ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
    ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {full[WIDTH], ovf, full[WIDTH-1:0]};
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic sub, input logic cin);
    int cnt;
    cnt = 0;
    while (!bus.in_ready && cnt < Bound) begin
      @(negedge clk);
      cnt++;
    end
    check("in_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = sub;
    bus.cin      = cin;
    @(posedge clk);
    exp_q.push_back(model(a, b, sub, cin));
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Waits for the result, optionally scrambling operands during RUN and stalling in DONE.
  task automatic recv(input string tag, input bit scramble, input int hold);
    int               cnt;
    logic [WIDTH+1:0] exp;
    cnt = 0;
    while (!bus.out_valid && cnt < Bound) begin
      if (scramble) begin
        bus.a   = WIDTH'($urandom);
        bus.b   = WIDTH'($urandom);
        bus.sub = 1'($urandom);
        bus.cin = 1'($urandom);
      end
      @(negedge clk);
      cnt++;
    end
    check({tag, "_latency"}, cnt, 32'd4);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = WIDTH'($urandom);
      bus.b        = WIDTH'($urandom);
      bus.sub      = 1'($urandom);
      @(negedge clk);
      check({tag, "_hold_sum"}, {16'd0, bus.sum}, {16'd0, exp[WIDTH-1:0]});
      check({tag, "_hold_flags"}, {30'd0, bus.cout, bus.ovf}, {30'd0, exp[WIDTH+1:WIDTH]});
      check({tag, "_hold_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      check({tag, "_hold_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    end
    bus.in_valid = 1'b0;
    check({tag, "_sum"}, {16'd0, bus.sum}, {16'd0, exp[WIDTH-1:0]});
    check({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, exp[WIDTH+1]});
    check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp[WIDTH]});
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_post_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_post_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int seen;
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_sum", {16'd0, bus.sum}, 32'd0);
    check("rst_cout", {31'd0, bus.cout}, 32'd0);
    check("rst_ovf", {31'd0, bus.ovf}, 32'd0);

    send(16'h1234, 16'h0FFF, 1'b0, 1'b0); recv("add1", 1'b0, 0);
    check("add1_model_sum", 32'(model(16'h1234, 16'h0FFF, 1'b0, 1'b0)), 32'h0_2233);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0); recv("add_carry", 1'b0, 0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0); recv("add_ovf", 1'b0, 0);
    send(16'h0005, 16'h0007, 1'b1, 1'b0); recv("sub_borrow", 1'b0, 0);
    send(16'h8000, 16'h0001, 1'b1, 1'b0); recv("sub_ovf", 1'b0, 0);
    send(16'h0005, 16'h0007, 1'b1, 1'b1); recv("sub_cin1a", 1'b0, 0);
    send(16'h8000, 16'h0001, 1'b1, 1'b1); recv("sub_cin1b", 1'b0, 0);
    send(16'hABCD, 16'h1111, 1'b0, 1'b1); recv("add_cin", 1'b0, 0);

    // Backpressure with ignored requests, then a follow-up op.
    send(16'h4321, 16'h1234, 1'b0, 1'b0); recv("bp", 1'b0, 5);
    send(16'h0F0F, 16'hF0F0, 1'b0, 1'b1); recv("bp_next", 1'b0, 0);

    send(16'h2468, 16'h1357, 1'b1, 1'b0); recv("scramble", 1'b1, 0);

    // Reset while idx=2 in RUN.
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(exp_q.pop_front());
    check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("abort_sum", {16'd0, bus.sum}, 32'd0);
    check("abort_flags", {30'd0, bus.cout, bus.ovf}, 32'd0);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("abort_no_result", seen, 32'd0);
    send(16'h0001, 16'h0001, 1'b0, 1'b0); recv("post_reset", 1'b0, 0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
